// File: rtl/aes_block_sched.sv
// Block scheduler between the USB RX/TX byte paths and the AES core. It packs RX bytes
// into a block, zero-pads a short final block, runs the core under a timeout, and drains the result to TX.
module aes_block_sched #(
  parameter int BLOCK_BYTES = 16,
  parameter int AES_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  input  logic                     rx_eop,
  output logic                     rx_ready,
  output logic [8*BLOCK_BYTES-1:0] aes_din,
  output logic                     aes_start,
  input  logic                     aes_done,
  input  logic [8*BLOCK_BYTES-1:0] aes_dout,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [15:0]              blocks_done,
  output logic [2:0]               dbg_state
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = $clog2(AES_TIMEOUT + 1);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // valid never waits for ready, and data is held stable while valid=1 and ready=0.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_PAD   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   drain_q, drain_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [W-1:0]    data_q, data_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic            eop_seen_q, eop_seen_d;
  logic            err_q, err_d;
  logic [15:0]     blocks_q, blocks_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drain_q    <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      sreg_q     <= '0;
      eop_seen_q <= 1'b0;
      err_q      <= 1'b0;
      blocks_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      sreg_q     <= sreg_d;
      eop_seen_q <= eop_seen_d;
      err_q      <= err_d;
      blocks_q   <= blocks_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    timer_d    = timer_q;
    data_d     = data_q;
    sreg_d     = sreg_q;
    eop_seen_d = eop_seen_q;
    err_d      = err_q;
    blocks_d   = blocks_q;
    rx_ready   = 1'b0;
    aes_start  = 1'b0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;

    case (state_q)
      S_IDLE, S_FILL: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (cnt_q == CW'(i)) data_d[8*(BLOCK_BYTES-1-i) +: 8] = rx_byte;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
            state_d    = S_START;
            eop_seen_d = rx_eop;
          end else if (rx_eop) begin
            state_d    = S_PAD;
            eop_seen_d = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_PAD: begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (CW'(i) >= cnt_q) data_d[8*(BLOCK_BYTES-1-i) +: 8] = 8'h00;
        end
        state_d = S_START;
      end
      S_START: begin
        aes_start = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over expiry when both land in the same cycle
        if (aes_done) begin
          sreg_d   = aes_dout;
          blocks_d = blocks_q + 16'd1;
          drain_d  = '0;
          state_d  = S_DRAIN;
        end else if (timer_q == TW'(AES_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          cnt_d      = '0;
          eop_seen_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DRAIN: begin
        tx_valid = 1'b1;
        tx_last  = eop_seen_q && (drain_q == CW'(BLOCK_BYTES - 1));
        if (tx_ready) begin
          sreg_d  = {sreg_q[W-9:0], 8'h00};
          drain_d = drain_q + 1'b1;
          if (drain_q == CW'(BLOCK_BYTES - 1)) begin
            cnt_d      = '0;
            eop_seen_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign aes_din     = data_q;
  assign tx_byte     = sreg_q[W-1 -: 8];
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;
  assign blocks_done = blocks_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_block_sched.sv
// Randomised bench for aes_block_sched: packet-level reference model feeds expected AES inputs
// and TX bytes into queues; an AES responder and a TX monitor pop and compare independently.
module tb_aes_block_sched;

  logic         clk;
  logic         rst;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_eop;
  logic         rx_ready;
  logic [127:0] aes_din;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_dout;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;
  logic         busy;
  logic         err_timeout;
  logic [15:0]  blocks_done;
  logic [2:0]   dbg_state;

  aes_block_sched dut (
    .clk(clk), .rst(rst),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_eop(rx_eop), .rx_ready(rx_ready),
    .aes_din(aes_din), .aes_start(aes_start), .aes_done(aes_done), .aes_dout(aes_dout),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .err_timeout(err_timeout), .blocks_done(blocks_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [8:0]   exp_q[$];      // {tx_last, tx_byte}
  logic [127:0] exp_blk_q[$];  // expected aes_din per launched block
  logic [7:0]   pkt[$];
  logic [15:0]  exp_blocks = 16'd0;
  logic [7:0]   aes_key = 8'hFF;
  int           done_delay = 5;  // 0: core never answers
  int           tx_mode = 0;     // 0 always ready, 1 random, 2 pattern 1,0,0, 3 never
  int           n_cmp = 0;
  int           n_err = 0;
  int           last_acc, start_cyc, done_cyc, first_tx_cyc, idle_cyc;
  logic         model_done = 1'b0;
  logic         spur_done = 1'b0;

  assign aes_done = model_done | spur_done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not seen or unexpected (t=%0t)", name, $time);
  endtask

  // ---------------- AES core responder ----------------
  initial begin
    logic [127:0] din;
    aes_dout = '0;
    forever begin
      @(negedge clk);
      if (aes_start && !rst) begin
        din = aes_din;
        start_cyc = cyc;
        if (exp_blk_q.size() == 0) fail("aes_start_unexpected");
        else chk("aes_din", din, exp_blk_q.pop_front());
        if (done_delay > 0) begin
          @(posedge clk);
          repeat (done_delay - 1) @(posedge clk);
          #1;
          model_done = 1'b1;
          aes_dout   = din ^ {16{aes_key}};
          done_cyc   = cyc;
          @(posedge clk);
          #1 model_done = 1'b0;
        end
      end
    end
  end

  // ---------------- TX ready driver ----------------
  initial begin
    int ph = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = (ph % 3 == 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // ---------------- TX monitor ----------------
  initial begin
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [8:0] prev_beat = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (tx_valid && !prev_valid) first_tx_cyc = cyc;
        if (prev_stall) begin
          chk("tx_valid_held", 128'(tx_valid), 128'(1'b1));
          chk("tx_stable_stall", 128'({tx_last, tx_byte}), 128'(prev_beat));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) fail("tx_unexpected_byte");
          else begin
            e = exp_q.pop_front();
            chk("tx_beat", 128'({tx_last, tx_byte}), 128'(e));
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_valid = tx_valid;
        prev_beat  = {tx_last, tx_byte};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic eop);
    bit ok = 0;
    int n = 0;
    rx_byte  = b;
    rx_eop   = eop;
    rx_valid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = rx_ready;
      if (ok) last_acc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    if (!ok) fail("rx_accept_timeout");
  endtask

  // Reference model: chop the packet into 16-byte blocks, zero-pad the tail,
  // predict the core input and, if the core answers in time, the TX stream.
  task automatic run_packet(input logic eop, input int max_gap);
    int n  = pkt.size();
    int nb = (n + 15) / 16;
    for (int blk = 0; blk < nb; blk++) begin
      logic [127:0] b = '0;
      for (int i = 0; i < 16; i++) begin
        int idx = blk * 16 + i;
        b[127 - 8*i -: 8] = (idx < n) ? pkt[idx] : 8'h00;
      end
      exp_blk_q.push_back(b);
      if (done_delay >= 1 && done_delay <= 64) begin
        exp_blocks = exp_blocks + 16'd1;
        for (int i = 0; i < 16; i++)
          exp_q.push_back({(eop && blk == nb - 1 && i == 15), b[127 - 8*i -: 8] ^ aes_key});
      end
    end
    for (int idx = 0; idx < n; idx++) begin
      send_byte(pkt[idx], eop && (idx == n - 1));
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic fill_random(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 3000);
    if (n >= 3000) fail("idle_timeout");
    idle_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; rx_byte = '0; rx_valid = 1'b0; rx_eop = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 128'(rx_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_outputs", 128'({aes_start, tx_valid, tx_last, err_timeout, tx_byte}), 128'(0));
    chk("rst_aes_din", aes_din, 128'(0));
    chk("rst_blocks", 128'(blocks_done), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // full block 00..0F, core output = input ^ FF after 5 cycles
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'(i));
    aes_key = 8'hFF; done_delay = 5; tx_mode = 0;
    run_packet(1'b0, 0);
    wait_idle();
    chk("start_latency_full", 128'(start_cyc - last_acc), 128'(1));
    chk("tx_latency", 128'(first_tx_cyc - done_cyc), 128'(1));
    chk("blocks_after_full", 128'(blocks_done), 128'(exp_blocks));

    // padded block AA BB CC with eop
    pkt.delete();
    pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC);
    aes_key = 8'h5A; done_delay = 7;
    run_packet(1'b1, 0);
    wait_idle();
    chk("start_latency_pad", 128'(start_cyc - last_acc), 128'(2));
    chk("blocks_after_pad", 128'(blocks_done), 128'(exp_blocks));

    // TX backpressure 1,0,0 pattern
    tx_mode = 2; aes_key = 8'h3C; done_delay = 4;
    fill_random(20);
    run_packet(1'b1, 1);
    wait_idle();
    chk("blocks_after_bp", 128'(blocks_done), 128'(exp_blocks));

    // randomised packets
    tx_mode = 1;
    for (int t = 0; t < 12; t++) begin
      logic eop = 1'($urandom_range(0, 1));
      aes_key = 8'($urandom_range(0, 255));
      done_delay = $urandom_range(1, 20);
      fill_random(eop ? $urandom_range(1, 40) : 16 * $urandom_range(1, 2));
      run_packet(eop, 3);
      wait_idle();
    end
    chk("blocks_after_random", 128'(blocks_done), 128'(exp_blocks));
    tx_mode = 0;

    // done on the final WAIT cycle wins over the timeout
    done_delay = 64; aes_key = 8'hC3;
    fill_random(16);
    run_packet(1'b0, 0);
    wait_idle();
    chk("done_at_64_no_err", 128'(err_timeout), 128'(1'b0));
    chk("blocks_after_64", 128'(blocks_done), 128'(exp_blocks));

    // spurious done while idle
    spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    @(negedge clk);
    chk("spurious_done_blocks", 128'(blocks_done), 128'(exp_blocks));
    chk("spurious_done_busy", 128'(busy), 128'(1'b0));
    @(posedge clk);
    #1;

    // timeout: core never answers
    done_delay = 0;
    fill_random(5);
    run_packet(1'b1, 0);
    wait_idle();
    chk("timeout_duration", 128'(idle_cyc - start_cyc), 128'(65));
    chk("timeout_err", 128'(err_timeout), 128'(1'b1));
    chk("timeout_rx_ready", 128'(rx_ready), 128'(1'b1));
    chk("timeout_blocks", 128'(blocks_done), 128'(exp_blocks));

    // reset in the middle of DRAIN
    tx_mode = 3; done_delay = 3; aes_key = 8'h11;
    fill_random(16);
    run_packet(1'b0, 0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tx_valid && n < 200);
      if (!tx_valid) fail("drain_not_reached");
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_drain_rst_busy", 128'(busy), 128'(1'b0));
    chk("mid_drain_rst_tx_valid", 128'(tx_valid), 128'(1'b0));
    chk("mid_drain_rst_rx_ready", 128'(rx_ready), 128'(1'b1));
    chk("mid_drain_rst_err", 128'(err_timeout), 128'(1'b0));
    chk("mid_drain_rst_blocks", 128'(blocks_done), 128'(0));
    exp_q.delete();
    exp_blocks = 16'd0;
    tx_mode = 0;
    @(posedge clk);
    #1;

    // counter wrap: preload 0xFFFF, then one block
    @(negedge clk);
    force dut.blocks_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut.blocks_q;
    exp_blocks = 16'hFFFF;
    done_delay = 2; aes_key = 8'h77;
    fill_random(9);
    run_packet(1'b1, 0);
    wait_idle();
    chk("blocks_wrap", 128'(blocks_done), 128'(16'h0000));
    chk("blocks_wrap_model", 128'(blocks_done), 128'(exp_blocks));

    chk("tx_queue_drained", 128'(exp_q.size()), 128'(0));
    chk("blk_queue_drained", 128'(exp_blk_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
